// File: rtl/udp_pkg.sv
// udp_pkg: constants and types shared by the UDP test-pattern sender and
// receiver. HELLO_BYTES holds "Hello World" with byte 0 in the top octet.
package udp_pkg;
  localparam int LEN_W     = 8;
  localparam int HELLO_LEN = 11;
  localparam logic [HELLO_LEN*8-1:0] HELLO_BYTES = 88'h48_65_6C_6C_6F_20_57_6F_72_6C_64;

  typedef enum logic {IDLE, RECV} udp_rx_state_t;

  // Byte idx of the pattern; 0 for idx beyond the pattern (caller flags those).
  function automatic logic [7:0] hello_byte(input logic [LEN_W-1:0] idx);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < HELLO_LEN; i++)
      if (int'(idx) == i) b = HELLO_BYTES[(HELLO_LEN-1-i)*8 +: 8];
    return b;
  endfunction
endpackage

// File: rtl/udp_rx_buffer.sv
// udp_rx_buffer: DEPTH x 8 simple dual-port RAM.
//   clk, rst_n            : clock, async active-low reset (read register only)
//   we_i/waddr_i/wdata_i  : write port
//   raddr_i -> rdata_o    : registered read port, 1-cycle latency
// Read and write to the same address in one cycle returns the old byte.
module udp_rx_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem_q [DEPTH];

  // Storage array intentionally has no reset.
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata_o <= '0;
    else        rdata_o <= mem_q[raddr_i];
endmodule

// File: rtl/udp_receiver.sv
// udp_receiver: captures a framed byte stream into a local buffer, counts
// the frame length and checks it against the "Hello World" pattern.
//   clk, rst_n        : clock, async active-low reset
//   rx_data, rx_valid : byte stream; a frame is a maximal run of rx_valid=1
//   rd_addr -> rd_data: registered buffer read port
//   busy              : frame in progress
//   frame_done        : 1-cycle pulse once a frame ends; status valid from then
//   frame_len/_match/_ovf : status of the last completed frame
module udp_receiver
  import udp_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int ADDR_W  = $clog2(MAX_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              frame_done,
  output logic [LEN_W-1:0]  frame_len,
  output logic              frame_match,
  output logic              frame_ovf
);
  localparam logic [LEN_W-1:0] HLEN    = LEN_W'(HELLO_LEN);
  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  udp_rx_state_t    state_q;
  logic [LEN_W-1:0] cnt_q;
  logic             ovf_q, mis_q;
  logic             busy_q, done_q, match_q, fovf_q;
  logic [LEN_W-1:0] len_q;

  logic              in_room, byte_bad, wr_en;
  logic [LEN_W-1:0]  idx;
  logic [ADDR_W-1:0] wr_addr;

  // In IDLE the incoming byte is byte 0 of a new frame regardless of the
  // stale count left over from the previous frame.
  always_comb begin
    idx      = (state_q == IDLE) ? '0 : cnt_q;
    in_room  = int'(idx) < MAX_LEN;
    wr_en    = rx_valid && in_room;
    wr_addr  = ADDR_W'(idx);
    byte_bad = (idx >= HLEN) || (rx_data != hello_byte(idx));
  end

  udp_rx_buffer #(.DEPTH(MAX_LEN), .AW(ADDR_W)) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (wr_en),
    .waddr_i(wr_addr),
    .wdata_i(rx_data),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      mis_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      len_q   <= '0;
      match_q <= 1'b0;
      fovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (rx_valid) begin
          state_q <= RECV;
          busy_q  <= 1'b1;
          cnt_q   <= LEN_W'(1);
          ovf_q   <= 1'b0;
          mis_q   <= byte_bad;
        end
        RECV: if (rx_valid) begin
          if (!in_room)         ovf_q <= 1'b1;
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + LEN_W'(1);
          if (byte_bad)         mis_q <= 1'b1;
        end else begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          len_q   <= cnt_q;
          match_q <= !mis_q && (cnt_q == HLEN) && !ovf_q;
          fovf_q  <= ovf_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign frame_len   = len_q;
  assign frame_match = match_q;
  assign frame_ovf   = fovf_q;
endmodule

// File: tb/tb_udp_receiver.sv
module tb_udp_receiver;
  localparam int MAX_LEN = 16;
  localparam int AW      = 4;

  logic          clk = 0, rst_n = 0;
  logic [7:0]    rx_data = 0;
  logic          rx_valid = 0;
  logic [AW-1:0] rd_addr = 0;
  logic [7:0]    rd_data, frame_len;
  logic          busy, frame_done, frame_match, frame_ovf;

  udp_receiver #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .frame_done(frame_done),
    .frame_len(frame_len), .frame_match(frame_match), .frame_ovf(frame_ovf));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0, nerr = 0;
  string HS = "Hello World";

  // reference model state
  byte unsigned frm[$];
  logic [7:0]   mem_m [MAX_LEN];
  int           exp_len;
  logic         exp_match, exp_ovf;

  // observations captured by run_frame / read_back
  logic       o_busy, o_pre_done, o_done, o_match, o_ovf, o_busy_end;
  logic [7:0] o_len;
  int         o_cyc;
  logic [7:0] o_rd [MAX_LEN];

  function automatic void model_frame();
    int n = frm.size();
    exp_len   = (n > 255) ? 255 : n;
    exp_ovf   = n > MAX_LEN;
    exp_match = (n == 11);
    for (int i = 0; i < n; i++) begin
      if (i < MAX_LEN) mem_m[i] = frm[i];
      if (i < 11 && frm[i] != HS[i]) exp_match = 0;
    end
  endfunction

  function automatic void set_hello();
    frm.delete();
    for (int i = 0; i < 11; i++) frm.push_back(HS[i]);
  endfunction

  // Called at a negedge; returns at the negedge where frame_done should be high.
  task automatic run_frame();
    model_frame();
    for (int i = 0; i < frm.size(); i++) begin
      rx_valid = 1; rx_data = frm[i];
      @(negedge clk);
      if (i == 0) o_busy = busy;
    end
    o_pre_done = frame_done;
    rx_valid = 0; rx_data = 0;
    @(negedge clk);
    o_done = frame_done; o_len = frame_len; o_match = frame_match;
    o_ovf = frame_ovf; o_busy_end = busy; o_cyc = cyc;
  endtask

  task automatic read_back(input int n);
    for (int i = 0; i < n; i++) begin
      rd_addr = AW'(i);
      @(negedge clk);
      o_rd[i] = rd_data;
    end
  endtask

  task automatic test_reset();
    #2;
    nvec++;
    if ({rd_data, busy, frame_done, frame_len, frame_match, frame_ovf} !== 20'h0) begin
      nerr++; $display("FAIL reset_outputs got %h want 0",
        {rd_data, busy, frame_done, frame_len, frame_match, frame_ovf});
    end
    @(negedge clk); rst_n = 1; @(negedge clk);
  endtask

  task automatic test_hello();
    set_hello(); run_frame();
    nvec++; if (o_busy !== 1) begin nerr++; $display("FAIL hello_busy got %b want 1", o_busy); end
    nvec++; if (o_pre_done !== 0) begin nerr++; $display("FAIL hello_early_done got %b want 0", o_pre_done); end
    nvec++; if (o_done !== 1) begin nerr++; $display("FAIL hello_done got %b want 1", o_done); end
    nvec++; if (o_busy_end !== 0) begin nerr++; $display("FAIL hello_busy_end got %b want 0", o_busy_end); end
    nvec++; if ({o_len, o_match, o_ovf} !== {8'd11, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL hello_status got len=%0d m=%b o=%b want len=11 m=1 o=0", o_len, o_match, o_ovf);
    end
    @(negedge clk);
    nvec++; if ({frame_done, frame_len, frame_match} !== {1'b0, 8'd11, 1'b1}) begin
      nerr++; $display("FAIL hello_hold got d=%b len=%0d m=%b want d=0 len=11 m=1", frame_done, frame_len, frame_match);
    end
    read_back(11);
    for (int i = 0; i < 11; i++) begin
      nvec++; if (o_rd[i] !== HS[i]) begin nerr++; $display("FAIL hello_rd[%0d] got %h want %h", i, o_rd[i], HS[i]); end
    end
  endtask

  task automatic test_mismatch();
    set_hello(); frm[4] = 8'h78; run_frame();
    nvec++; if ({o_done, o_len, o_match, o_ovf} !== {1'b1, 8'd11, 1'b0, 1'b0}) begin
      nerr++; $display("FAIL hellx_status got d=%b len=%0d m=%b o=%b want d=1 len=11 m=0 o=0", o_done, o_len, o_match, o_ovf);
    end
    @(negedge clk);
    set_hello(); frm = frm[0:4]; run_frame();
    nvec++; if ({o_done, o_len, o_match, o_ovf} !== {1'b1, 8'd5, 1'b0, 1'b0}) begin
      nerr++; $display("FAIL short_status got d=%b len=%0d m=%b o=%b want d=1 len=5 m=0 o=0", o_done, o_len, o_match, o_ovf);
    end
    @(negedge clk);
    set_hello(); frm.push_back(8'h21); run_frame();
    nvec++; if ({o_len, o_match} !== {8'd12, 1'b0}) begin
      nerr++; $display("FAIL long_hello got len=%0d m=%b want len=12 m=0", o_len, o_match);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    frm.delete();
    for (int i = 0; i < 20; i++) frm.push_back(8'(i));
    run_frame();
    nvec++; if ({o_done, o_len, o_match, o_ovf} !== {1'b1, 8'h14, 1'b0, 1'b1}) begin
      nerr++; $display("FAIL ovf_status got d=%b len=%0d m=%b o=%b want d=1 len=20 m=0 o=1", o_done, o_len, o_match, o_ovf);
    end
    read_back(16);
    for (int i = 0; i < 16; i++) begin
      nvec++; if (o_rd[i] !== 8'(i)) begin nerr++; $display("FAIL ovf_rd[%0d] got %h want %h", i, o_rd[i], 8'(i)); end
    end
    frm.delete();
    for (int i = 0; i < 300; i++) frm.push_back(8'($urandom));
    run_frame();
    nvec++; if ({o_len, o_ovf, o_match} !== {8'd255, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL sat_status got len=%0d o=%b m=%b want len=255 o=1 m=0", o_len, o_ovf, o_match);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int c1;
    logic m1;
    set_hello(); run_frame();
    c1 = o_cyc; m1 = o_match & o_done;
    run_frame();
    nvec++; if (m1 !== 1'b1) begin nerr++; $display("FAIL b2b_first got %b want 1", m1); end
    nvec++; if ({o_done, o_match, o_len} !== {1'b1, 1'b1, 8'd11}) begin
      nerr++; $display("FAIL b2b_second got d=%b m=%b len=%0d want d=1 m=1 len=11", o_done, o_match, o_len);
    end
    nvec++; if (o_cyc - c1 !== 12) begin nerr++; $display("FAIL b2b_spacing got %0d want 12", o_cyc - c1); end
    @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    rd_addr = 0;
    set_hello();
    for (int i = 0; i < 6; i++) begin
      rx_valid = 1; rx_data = frm[i]; @(negedge clk);
    end
    #1 rst_n = 0; #1;
    nvec++;
    if ({rd_data, busy, frame_done, frame_len, frame_match, frame_ovf} !== 20'h0) begin
      nerr++; $display("FAIL midrst_outputs got %h want 0",
        {rd_data, busy, frame_done, frame_len, frame_match, frame_ovf});
    end
    rx_valid = 0;
    @(negedge clk); @(negedge clk); rst_n = 1; @(negedge clk);
    run_frame();
    nvec++; if ({o_done, o_match, o_len, o_ovf} !== {1'b1, 1'b1, 8'd11, 1'b0}) begin
      nerr++; $display("FAIL midrst_after got d=%b m=%b len=%0d o=%b want d=1 m=1 len=11 o=0", o_done, o_match, o_len, o_ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      int n, k, sel;
      sel = $urandom_range(0, 3);
      if (sel == 0) set_hello();
      else if (sel == 1) begin
        set_hello(); k = $urandom_range(0, 10); frm[k] = frm[k] ^ 8'(1 << $urandom_range(0, 7));
      end else begin
        frm.delete(); n = $urandom_range(1, 24);
        for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
      end
      run_frame();
      nvec++; if ({o_done, o_len, o_match, o_ovf} !== {1'b1, 8'(exp_len), exp_match, exp_ovf}) begin
        nerr++; $display("FAIL rnd%0d_status got d=%b len=%0d m=%b o=%b want d=1 len=%0d m=%b o=%b",
          t, o_done, o_len, o_match, o_ovf, exp_len, exp_match, exp_ovf);
      end
      n = (exp_len < MAX_LEN) ? exp_len : MAX_LEN;
      read_back(n);
      for (int i = 0; i < n; i++) begin
        nvec++; if (o_rd[i] !== mem_m[i]) begin
          nerr++; $display("FAIL rnd%0d_rd[%0d] got %h want %h", t, i, o_rd[i], mem_m[i]);
        end
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_hello();
    test_mismatch();
    test_overflow();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
